// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, bus operation codes and
// data_mask encodings common to the arbiter and the cpu.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  typedef enum logic {
    BUS_OP_RD = 1'b0,
    BUS_OP_WR = 1'b1
  } bus_op_e;

  localparam logic [3:0] DATA_MASK_NONE  = 4'b0000;
  localparam logic [3:0] DATA_MASK_BYTE0 = 4'b0001;
  localparam logic [3:0] DATA_MASK_HALF0 = 4'b0011;
  localparam logic [3:0] DATA_MASK_HALF1 = 4'b1100;
  localparam logic [3:0] DATA_MASK_WORD  = 4'b1111;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection over a candidate vector: lowest index in
// fixed mode, first index at or above the pointer (wrapping) in rotate mode.
module arb_picker #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    cand,
  input  logic [ID_W-1:0] ptr,
  input  logic            rr_mode,
  output logic [ID_W-1:0] winner,
  output logic            found
);

  int              idx;
  logic [ID_W-1:0] sel;

  // NOTE: every output and temporary gets a default before any branch so
  // no path leaves a value held, which would infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < N; i++) begin
      idx = rr_mode ? (int'(ptr) + i) % N : i;
      sel = ID_W'(idx);
      if (!found && cand[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Multi-master bus arbiter with turnaround cycle between owners and
// stall-timeout revocation with a penalty mask.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ID_W           = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] bus_req,
  output logic [NUM_MASTERS-1:0] bus_grant,
  input  logic                   fc_bus,
  output logic                   owner_valid,
  output logic [ID_W-1:0]        owner_id,
  output logic                   timeout_pulse,
  output logic [ID_W-1:0]        timeout_id
);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] pen_q, pen_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic                   tp_q, tp_d;
  logic [ID_W-1:0]        tid_q, tid_d;

  logic [ID_W-1:0]        winner;
  logic                   found;
  logic                   timeout_hit;
  logic                   enter_own;

  arb_picker #(.N(NUM_MASTERS), .ID_W(ID_W)) u_picker (
    .cand    (bus_req & ~pen_q),
    .ptr     (ptr_q),
    .rr_mode (ROUND_ROBIN != 0),
    .winner  (winner),
    .found   (found)
  );

  assign enter_own = (state_q == IDLE) && found;

  // Owned-cycle counter; fc_bus restarts it, so a live transfer is never revoked.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (enter_own)               cnt_d = '0;
      else if (state_q == OWN)     cnt_d = fc_bus ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end

    assign timeout_hit = (state_q == OWN) && bus_req[owner_q] && !fc_bus &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    tp_d    = 1'b0;
    tid_d   = tid_q;
    pen_d   = pen_q & bus_req;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d         = OWN;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          if (ROUND_ROBIN != 0)
            ptr_d = (winner == ID_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
      end
      OWN: begin
        // Release takes precedence over a coincident timeout.
        if (!bus_req[owner_q]) begin
          grant_d = '0;
          state_d = TURN;
        end else if (timeout_hit) begin
          grant_d        = '0;
          tp_d           = 1'b1;
          tid_d          = owner_q;
          pen_d[owner_q] = 1'b1;
          state_d        = TURN;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      pen_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      tp_q    <= 1'b0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pen_q   <= pen_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tp_q    <= tp_d;
      tid_q   <= tid_d;
    end
  end

  assign bus_grant     = grant_q;
  assign owner_valid   = |grant_q;
  assign owner_id      = owner_q;
  assign timeout_pulse = tp_q;
  assign timeout_id    = tid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter (timeout 8)
// against a behavioural model through an expected-output scoreboard.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_rr = '0, req_fx = '0;
  logic       fc_rr = 1'b0, fc_fx = 1'b0;
  logic [3:0] gnt_rr, gnt_fx;
  logic       ov_rr, ov_fx, tp_rr, tp_fx;
  logic [1:0] id_rr, id_fx, tid_rr, tid_fx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(N), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(TO)) dut_rr (
    .clk(clk), .rst(rst), .bus_req(req_rr), .bus_grant(gnt_rr), .fc_bus(fc_rr),
    .owner_valid(ov_rr), .owner_id(id_rr), .timeout_pulse(tp_rr), .timeout_id(tid_rr)
  );

  bus_arbiter #(.NUM_MASTERS(N), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(TO)) dut_fx (
    .clk(clk), .rst(rst), .bus_req(req_fx), .bus_grant(gnt_fx), .fc_bus(fc_fx),
    .owner_valid(ov_fx), .owner_id(id_fx), .timeout_pulse(tp_fx), .timeout_id(tid_fx)
  );

  typedef struct {
    int         st;    // 0 idle, 1 own, 2 turn
    int         ptr;
    logic [3:0] pen;
    int         owner;
    int         cnt;
    logic [3:0] grant;
    logic       tp;
    int         tid;
  } model_t;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       tp;
    logic [1:0] tid;
  } exp_t;

  model_t m_rr, m_fx;
  exp_t   q_rr[$], q_fx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t s;
    s.st = 0; s.ptr = 0; s.pen = '0; s.owner = 0; s.cnt = 0;
    s.grant = '0; s.tp = 1'b0; s.tid = 0;
    return s;
  endfunction

  // One clock edge of the arbiter's documented behaviour.
  function automatic model_t model_step(model_t s, logic [3:0] req, logic fc, bit rr);
    model_t     n = s;
    logic [3:0] cand = req & ~s.pen;
    n.tp  = 1'b0;
    n.pen = s.pen & req;
    if (s.st == 0) begin
      for (int i = 0; i < N; i++) begin
        int k = rr ? (s.ptr + i) % N : i;
        if (n.st == 0 && cand[k]) begin
          n.st = 1; n.owner = k; n.cnt = 0;
          n.grant = 4'(1 << k);
          if (rr) n.ptr = (k + 1) % N;
        end
      end
    end else if (s.st == 1) begin
      if (!req[s.owner]) begin
        n.grant = '0; n.st = 2;
      end else if (!fc && s.cnt == TO - 1) begin
        n.grant = '0; n.st = 2; n.tp = 1'b1; n.tid = s.owner;
        n.pen[s.owner] = 1'b1;
      end else begin
        n.cnt = fc ? 0 : s.cnt + 1;
      end
    end else begin
      n.st = 0;
    end
    return n;
  endfunction

  function automatic exp_t to_exp(model_t s);
    exp_t e;
    e.grant = s.grant; e.id = 2'(s.owner); e.tp = s.tp; e.tid = 2'(s.tid);
    return e;
  endfunction

  task automatic compare(input string who, input exp_t e, input logic [3:0] g,
                         input logic ov, input logic [1:0] id, input logic tp,
                         input logic [1:0] tid);
    check({who, "_grant"}, 32'(g), 32'(e.grant));
    check({who, "_valid"}, 32'(ov), 32'(|e.grant));
    check({who, "_id"}, 32'(id), 32'(e.id));
    check({who, "_tpulse"}, 32'(tp), 32'(e.tp));
    check({who, "_tid"}, 32'(tid), 32'(e.tid));
    check({who, "_onehot0"}, 32'($onehot0(g)), 32'(1));
  endtask

  // Drive one cycle on both instances, push model expectations, compare after the edge.
  task automatic step(input logic [3:0] ra, input logic fa, input logic [3:0] rb, input logic fb);
    req_rr = ra; fc_rr = fa; req_fx = rb; fc_fx = fb;
    m_rr = model_step(m_rr, ra, fa, 1'b1);
    m_fx = model_step(m_fx, rb, fb, 1'b0);
    q_rr.push_back(to_exp(m_rr));
    q_fx.push_back(to_exp(m_fx));
    @(posedge clk); #1;
    compare("rr", q_rr.pop_front(), gnt_rr, ov_rr, id_rr, tp_rr, tid_rr);
    compare("fx", q_fx.pop_front(), gnt_fx, ov_fx, id_fx, tp_fx, tid_fx);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req_rr = '0; req_fx = '0; fc_rr = 1'b0; fc_fx = 1'b0;
    rst = 1'b0;
    m_rr = model_reset(); m_fx = model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(gnt_rr | gnt_fx), 32'(0));
    check({tag, "_valid"}, 32'(ov_rr | ov_fx), 32'(0));
    check({tag, "_id"}, 32'(id_rr | id_fx), 32'(0));
    check({tag, "_tpulse"}, 32'(tp_rr | tp_fx), 32'(0));
    check({tag, "_tid"}, 32'(tid_rr | tid_fx), 32'(0));
  endtask

  initial begin
    int seq[$];
    int held;
    int tp_count;
    logic [3:0] prev_g;
    logic [3:0] ra;

    m_rr = model_reset(); m_fx = model_reset();
    #3 check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Single master request, hold, release, turnaround.
    step(4'b0000, 0, 4'b0000, 0);
    step(4'b0001, 0, 4'b0000, 0);
    check("t1_grant", 32'(gnt_rr), 32'(4'b0001));
    repeat (3) step(4'b0001, 0, 4'b0000, 0);
    step(4'b0000, 0, 4'b0000, 0);
    check("t1_turn", 32'(gnt_rr), 32'(0));
    step(4'b0000, 0, 4'b0000, 0);

    // Round-robin rotation with all masters requesting.
    do_reset();
    held = 0; prev_g = '0;
    for (int c = 0; c < 40 && seq.size() < 5; c++) begin
      ra = 4'b1111;
      if (m_rr.st == 1 && held >= 2) ra[m_rr.owner] = 1'b0;
      step(ra, 0, 4'b0000, 0);
      held = (m_rr.st == 1) ? held + 1 : 0;
      if (gnt_rr != 0 && prev_g == 0) seq.push_back(int'(id_rr));
      prev_g = gnt_rr;
    end
    check("t2_count", 32'(seq.size()), 32'(5));
    for (int i = 0; i < seq.size() && i < 5; i++)
      check("t2_order", 32'(seq[i]), 32'(i % N));
    repeat (3) step(4'b0000, 0, 4'b0000, 0);

    // Fixed priority: no preemption of the current owner.
    step(4'b0000, 0, 4'b0100, 0);
    check("t3_own2", 32'(gnt_fx), 32'(4'b0100));
    repeat (2) step(4'b0000, 0, 4'b0100, 0);
    repeat (3) step(4'b0000, 0, 4'b0101, 0);
    check("t3_nopreempt", 32'(gnt_fx), 32'(4'b0100));
    step(4'b0000, 0, 4'b0001, 0);
    check("t3_turn", 32'(gnt_fx), 32'(0));
    step(4'b0000, 0, 4'b0001, 0);
    step(4'b0000, 0, 4'b0001, 0);
    check("t3_grant0", 32'(gnt_fx), 32'(4'b0001));
    repeat (3) step(4'b0000, 0, 4'b0000, 0);

    // Timeout of master 1; master 3 wins next, master 1 penalised until it drops req.
    step(4'b0010, 0, 4'b0000, 0);
    for (int i = 0; i < 7; i++) begin
      step((i >= 2) ? 4'b1010 : 4'b0010, 0, 4'b0000, 0);
      check("t4_held", 32'(gnt_rr), 32'(4'b0010));
    end
    step(4'b1010, 0, 4'b0000, 0);
    check("t4_revoke", 32'(gnt_rr), 32'(0));
    check("t4_pulse", 32'(tp_rr), 32'(1));
    check("t4_tid", 32'(tid_rr), 32'(1));
    step(4'b1010, 0, 4'b0000, 0);
    check("t4_pulse_one", 32'(tp_rr), 32'(0));
    step(4'b1010, 0, 4'b0000, 0);
    check("t4_grant3", 32'(gnt_rr), 32'(4'b1000));
    repeat (3) step(4'b0010, 0, 4'b0000, 0);
    check("t4_penalised", 32'(gnt_rr), 32'(0));
    step(4'b0000, 0, 4'b0000, 0);
    step(4'b0010, 0, 4'b0000, 0);
    check("t4_regrant1", 32'(gnt_rr), 32'(4'b0010));
    repeat (3) step(4'b0000, 0, 4'b0000, 0);

    // Boundaries on fixed instance: fc at the limit wins; release at the limit wins.
    step(4'b0000, 0, 4'b0010, 0);
    repeat (7) step(4'b0000, 0, 4'b0010, 0);
    step(4'b0000, 0, 4'b0010, 1);
    check("b_fc_wins", 32'(tp_fx), 32'(0));
    check("b_fc_hold", 32'(gnt_fx), 32'(4'b0010));
    repeat (7) step(4'b0000, 0, 4'b0010, 0);
    step(4'b0000, 0, 4'b0000, 0);
    check("b_rel_wins", 32'(tp_fx), 32'(0));
    step(4'b0000, 0, 4'b0010, 0);
    step(4'b0000, 0, 4'b0010, 0);
    check("b_no_penalty", 32'(gnt_fx), 32'(4'b0010));
    step(4'b0000, 0, 4'b0000, 0);

    // Periodic fc keeps the owner alive for 100 cycles.
    tp_count = 0;
    for (int c = 0; c < 100; c++) begin
      step(4'b0010, (c % 5 == 4), 4'b0000, 0);
      if (tp_rr) tp_count++;
    end
    check("t5_no_timeout", 32'(tp_count), 32'(0));
    check("t5_still_owner", 32'(gnt_rr), 32'(4'b0010));

    // Asynchronous reset mid-ownership drops everything before the next edge.
    #2 rst = 1'b0;
    #1 check_reset_outputs("t6_async");
    m_rr = model_reset(); m_fx = model_reset();
    req_rr = '0;
    @(posedge clk); #1 rst = 1'b1;
    step(4'b0000, 0, 4'b0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
